vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines.
REQ-005 CLOCK_50  in  1  sole clock, 50 MHz; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rgb_in  in  24  upstream pixel {R,G,B}, 8 bits each, valid in the cycle pix_req is high.
REQ-008 pix_req  out  1  one-CLOCK_50-cycle request strobe for pixel (pix_x, pix_y), active area only.
REQ-009 pix_x / pix_y  out  10 / 10  coordinates of the requested pixel.
REQ-010 frame_start  out  1  one-cycle pulse coincident with pix_req for (0,0).
REQ-011 VGA_R / VGA_G / VGA_B  out  8 each  registered pixel colour.
REQ-012 VGA_HS / VGA_VS  out  1 each  active-low syncs.
REQ-013 VGA_CLK  out  1  25 MHz pixel clock, CLOCK_50 divided by 2.
REQ-014 VGA_BLANK_N  out  1  high only while the displayed pixel is in the active area.
REQ-015 VGA_SYNC_N  out  1  constant 0.

Function
REQ-016 A toggle register generates pix_en, high every second CLOCK_50 cycle; VGA_CLK = ~pix_en register, so outputs change at the VGA_CLK falling edge.
REQ-017 hcnt (10 b) increments on pix_en and wraps from H_TOTAL-1 = 799 to 0; vcnt (10 b) increments when hcnt wraps and wraps from V_TOTAL-1 = 524 to 0.
REQ-018 pix_req = pix_en AND hcnt < H_ACTIVE AND vcnt < V_ACTIVE; pix_x = hcnt, pix_y = vcnt, both combinational from counters.
REQ-019 Stage 1 (counter stage) decodes hs_raw = low for hcnt in [656,751], vs_raw = low for vcnt in [490,491], act_raw = active area.
REQ-020 Stage 2 registers rgb_in (or 0 when act_raw=0), hs_raw, vs_raw, act_raw on pix_en; latency from pix_req to the matching VGA_R/G/B/HS/VS/BLANK_N = exactly 2 CLOCK_50 cycles (one pixel).
REQ-021 Colour outputs are forced to 0 whenever VGA_BLANK_N = 0.
REQ-022 Syncs and blank are aligned on the same register stage as colour; no skew permitted.
REQ-023 Simultaneous hcnt and vcnt wrap (799,524 -> 0,0) occurs on one pix_en; frame_start asserts with the next pix_req.
REQ-024 Upstream has no stall; rgb_in sampled on pix_req regardless of source readiness.

Reset
REQ-025 While reset = 1: hcnt = 0, vcnt = 0, pix_en toggle = 0, VGA_R/G/B = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0, pix_req = 0, frame_start = 0.
REQ-026 Reset asserted mid-frame aborts the frame; the first pix_en after release starts at (0,0) with frame_start.
REQ-027 VGA_SYNC_N = 0 in and out of reset.

Configuration
REQ-028 Macro VGA_TIMING_COLORBAR_EN: when defined, rgb_in is ignored and stage 2 loads 8 vertical bars of 80 pixels, bar index = pix_x[9:4]/5, colours white, yellow, cyan, green, magenta, red, blue, black (channels 8'hFF / 8'h00).
REQ-029 Without VGA_TIMING_COLORBAR_EN, colour is taken solely from rgb_in; no colour-bar logic is synthesised.

Verification
REQ-030 Reset 5 cycles, release, count CLOCK_50 between VGA_HS falling edges -> 1600; HS low width -> 192 cycles.
REQ-031 Count VGA_HS falls between VGA_VS falling edges -> 525; VS low width -> 2 lines (3200 cycles).
REQ-032 Drive rgb_in = {pix_x[7:0], pix_y[7:0], 8'hA5} -> VGA_R/G/B equal that value for the same pixel exactly 2 cycles after pix_req; 307200 pix_req per frame.
REQ-033 Check blanking: for hcnt 640..799 or vcnt 480..524 -> VGA_BLANK_N = 0 and RGB = 0.
REQ-034 Assert reset at (300,200) for 1 cycle -> outputs take reset values next edge; after release frame_start with pix_x = 0, pix_y = 0 within 2 cycles.
REQ-035 With VGA_TIMING_COLORBAR_EN, pixel (85,10) -> {FF,FF,00}; pixel (639,479) -> {00,00,00}.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing, pixel request and VGA outputs.
// Define VGA_TIMING_COLORBAR_EN to replace rgb_in with 8 built-in colour bars.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [23:0] rgb_in,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_CLK,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        pix_en;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        h_last;
  logic        v_last;
  logic        act_raw;
  logic        hs_raw;
  logic        vs_raw;
  logic [23:0] pix_rgb;

  logic [23:0] cap_rgb;
  logic        cap_hs;
  logic        cap_vs;
  logic        cap_act;

  logic [23:0] out_rgb;
  logic        out_hs;
  logic        out_vs;
  logic        out_act;

  // Pixel-rate enable: toggles every CLOCK_50 cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) pix_en <= 1'b0;
    else       pix_en <= ~pix_en;
  end

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // Raster counters; both wrap on the same pix_en at frame end.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  assign act_raw = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_raw  = ~((hcnt >= HS_BEG) && (hcnt <= HS_END));
  assign vs_raw  = ~((vcnt >= VS_BEG) && (vcnt <= VS_END));

  assign pix_req     = pix_en & act_raw;
  assign frame_start = pix_req & (hcnt == '0) & (vcnt == '0);
  assign pix_x       = hcnt;
  assign pix_y       = vcnt;

`ifdef VGA_TIMING_COLORBAR_EN
  logic [2:0] bar;
  logic       unused_rgb;

  assign unused_rgb = ^rgb_in;

  // Bar colour: R/G/B are on for white..black in the classic order.
  always_comb begin
    bar     = 3'(hcnt[9:4] / 6'd5);
    pix_rgb = '0;
    if (act_raw) begin
      pix_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    end
  end
`else
  assign pix_rgb = act_raw ? rgb_in : '0;
`endif

  // Capture colour and decodes in the pix_req cycle (no upstream stall).
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cap_rgb <= '0;
      cap_hs  <= 1'b1;
      cap_vs  <= 1'b1;
      cap_act <= 1'b0;
    end else if (pix_en) begin
      cap_rgb <= pix_rgb;
      cap_hs  <= hs_raw;
      cap_vs  <= vs_raw;
      cap_act <= act_raw;
    end
  end

  // Launch on the half-period so all outputs move on VGA_CLK fall.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_rgb <= '0;
      out_hs  <= 1'b1;
      out_vs  <= 1'b1;
      out_act <= 1'b0;
    end else if (!pix_en) begin
      out_rgb <= cap_act ? cap_rgb : '0;
      out_hs  <= cap_hs;
      out_vs  <= cap_vs;
      out_act <= cap_act;
    end
  end

  assign VGA_R       = out_rgb[23:16];
  assign VGA_G       = out_rgb[15:8];
  assign VGA_B       = out_rgb[7:0];
  assign VGA_HS      = out_hs;
  assign VGA_VS      = out_vs;
  assign VGA_BLANK_N = out_act;
  assign VGA_CLK     = ~pix_en;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random rgb stimulus vs. an arithmetic raster model.
// Small raster for per-cycle checks; default-size instance for line timing.
module tb_vga_timing_gen;

  localparam int HA = 40;
  localparam int HF = 4;
  localparam int HSY = 8;
  localparam int HB = 6;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VSY = 2;
  localparam int VB = 3;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FR = 2 * HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] rgb = '0;

  logic        req;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        fs;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        hs;
  logic        vs;
  logic        vclk;
  logic        blank_n;
  logic        sync_n;

  logic        d2_unused_req;
  logic [9:0]  d2_unused_x;
  logic [9:0]  d2_unused_y;
  logic        d2_unused_fs;
  logic [7:0]  d2_unused_r;
  logic [7:0]  d2_unused_g;
  logic [7:0]  d2_unused_b;
  logic        hs2;
  logic        d2_unused_vs;
  logic        d2_unused_clk;
  logic        d2_unused_bn;
  logic        d2_unused_sn;

  int checks = 0;
  int failures = 0;
  int k = 0;
  bit live = 1'b0;
  logic [23:0] rgb_ring [4];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .rgb_in(rgb),
    .pix_req(req), .pix_x(px), .pix_y(py), .frame_start(fs),
    .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_CLK(vclk),
    .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n)
  );

  vga_timing_gen dut2 (
    .CLOCK_50(clk), .reset(reset), .rgb_in(rgb),
    .pix_req(d2_unused_req), .pix_x(d2_unused_x),
    .pix_y(d2_unused_y), .frame_start(d2_unused_fs),
    .VGA_R(d2_unused_r), .VGA_G(d2_unused_g), .VGA_B(d2_unused_b),
    .VGA_HS(hs2), .VGA_VS(d2_unused_vs), .VGA_CLK(d2_unused_clk),
    .VGA_BLANK_N(d2_unused_bn), .VGA_SYNC_N(d2_unused_sn)
  );

  always #5 clk = ~clk;

  // k = CLOCK_50 edges since reset release (0 while in reset)
  always @(posedge clk) begin
    if (reset) begin
      k <= 0;
      live <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", nm, k, act, exp);
    end
  endtask

  function automatic logic [23:0] colour(input int h,
                                         input logic [23:0] src);
`ifdef VGA_TIMING_COLORBAR_EN
    logic [2:0] bi;
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    bi = 3'((h / 16) / 5);
    return tbl[bi];
`else
    return src;
`endif
  endfunction

  // Expected outputs from raster arithmetic on the edge count k.
  task automatic compare();
    int n, h, v, kp, m, ph, pv;
    logic [23:0] ec;
    logic act, ehs, evs;
    if (!live) return;
    n = k / 2;
    h = n % HT;
    v = (n / HT) % VT;
    chk("pix_x", 32'(px), 32'(h));
    chk("pix_y", 32'(py), 32'(v));
    chk("pix_req", 32'(req), 32'((k % 2 == 1) && h < HA && v < VA));
    chk("frame_start", 32'(fs), 32'((k % 2 == 1) && h == 0 && v == 0));
    chk("vga_clk", 32'(vclk), 32'(k % 2 == 0));
    chk("sync_n", 32'(sync_n), 32'(0));
    kp = (k % 2 == 1) ? k - 2 : k - 3;
    if (kp < 1) begin
      ec = '0; act = 1'b0; ehs = 1'b1; evs = 1'b1;
    end else begin
      m = (kp - 1) / 2;
      ph = m % HT;
      pv = (m / HT) % VT;
      act = (ph < HA) && (pv < VA);
      ehs = !(ph >= HA + HF && ph < HA + HF + HSY);
      evs = !(pv >= VA + VF && pv < VA + VF + VSY);
      ec = act ? colour(ph, rgb_ring[kp % 4]) : 24'h0;
    end
    chk("rgb", 32'({r, g, b}), 32'(ec));
    chk("hs", 32'(hs), 32'(ehs));
    chk("vs", 32'(vs), 32'(evs));
    chk("blank_n", 32'(blank_n), 32'(act));
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    rgb = 24'($urandom);
    rgb_ring[k % 4] = rgb;
  endtask

  initial begin
    int nrun;
    bit got;
    logic pv, ph;
    int hs_falls, period, low;

    repeat (5) step();
    reset = 1'b0;
    repeat (2 * FR + 500) step();

    nrun = $urandom_range(800, 1800);
    repeat (nrun) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (fs === 1'b1) begin
        got = 1'b1;
        chk("restart_x", 32'(px), 32'(0));
        chk("restart_y", 32'(py), 32'(0));
        break;
      end
    end
    chk("restart_fs", 32'(got), 32'(1));

    hs_falls = 0; period = 0; low = 0; got = 1'b0;
    pv = vs;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      if (pv === 1'b1 && vs === 1'b0) begin got = 1'b1; break; end
      pv = vs;
    end
    if (got) begin
      pv = vs; ph = hs;
      for (int i = 1; i < 2 * FR; i++) begin
        step();
        if (ph === 1'b1 && hs === 1'b0) hs_falls++;
        if (pv === 1'b0 && vs === 1'b1 && low == 0) low = i;
        if (pv === 1'b1 && vs === 1'b0) begin period = i; break; end
        pv = vs; ph = hs;
      end
    end
    chk("vs_lines", 32'(hs_falls), 32'(19));
    chk("vs_low", 32'(low), 32'(232));
    chk("vs_period", 32'(period), 32'(2204));

    period = 0; low = 0; got = 1'b0;
    ph = hs2;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (ph === 1'b1 && hs2 === 1'b0) begin got = 1'b1; break; end
      ph = hs2;
    end
    if (got) begin
      ph = hs2;
      for (int i = 1; i < 4000; i++) begin
        step();
        if (ph === 1'b0 && hs2 === 1'b1 && low == 0) low = i;
        if (ph === 1'b1 && hs2 === 1'b0) begin period = i; break; end
        ph = hs2;
      end
    end
    chk("hs_low_640", 32'(low), 32'(192));
    chk("hs_period_640", 32'(period), 32'(1600));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
